// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL enable-clock sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    ST_RST       = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_EN_SEQ    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam int DEF_RST_CYCLES   = 32;
  localparam int DEF_LOCK_FILT    = 16;
  localparam int DEF_EN_GAP       = 8;
  localparam int DEF_LOCK_TIMEOUT = 1048576;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into clk.
module lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops; both clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_enclk_seq.sv
// PLL reset / lock-filter / staggered clock-enable sequencer.
// Every output is a flop; decisions use only the synchronised lock.
module pll_enclk_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_FILT    = DEF_LOCK_FILT,
  parameter int EN_GAP       = DEF_EN_GAP,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic       clkin,
  input  logic       resetn,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [2:0] enclk,
  output logic       ready,
  output logic [7:0] relock_cnt,
  output logic       timeout
);

  localparam int RW = cnt_width(RST_CYCLES);
  localparam int FW = cnt_width(LOCK_FILT);
  localparam int GW = cnt_width(EN_GAP);
  localparam int TW = cnt_width(LOCK_TIMEOUT);

  // Terminal values: each counter stops one short of its parameter.
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(EN_GAP - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);

  logic          lock_s;
  state_t        state, state_next;
  logic [RW-1:0] rst_cnt, rst_cnt_next;
  logic [FW-1:0] filt_cnt, filt_cnt_next;
  logic [GW-1:0] gap_cnt, gap_cnt_next;
  logic [TW-1:0] to_cnt, to_cnt_next;
  logic          pll_reset_next;
  logic [2:0]    enclk_next;
  logic          ready_next;
  logic          timeout_next;
  logic [7:0]    relock_next;
  logic          filt_done;

  lock_sync u_lock_sync (
    .clk   (clkin),
    .rst_n (resetn),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign filt_done = lock_s && (filt_cnt == FILT_LAST);

  // State, counters and registered outputs.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_RST;
      rst_cnt    <= '0;
      filt_cnt   <= '0;
      gap_cnt    <= '0;
      to_cnt     <= '0;
      pll_reset  <= 1'b1;
      enclk      <= 3'b000;
      ready      <= 1'b0;
      timeout    <= 1'b0;
      relock_cnt <= 8'd0;
    end else begin
      state      <= state_next;
      rst_cnt    <= rst_cnt_next;
      filt_cnt   <= filt_cnt_next;
      gap_cnt    <= gap_cnt_next;
      to_cnt     <= to_cnt_next;
      pll_reset  <= pll_reset_next;
      enclk      <= enclk_next;
      ready      <= ready_next;
      timeout    <= timeout_next;
      relock_cnt <= relock_next;
    end
  end

  // Next-state decision; a lock loss outranks any pending enable step.
  always_comb begin
    state_next = state;
    case (state)
      ST_RST: begin
        if (rst_cnt == RST_LAST) state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (filt_done)                state_next = ST_EN_SEQ;
        else if (to_cnt == TO_LAST)   state_next = ST_RST;
      end
      ST_EN_SEQ: begin
        if (!lock_s)                                    state_next = ST_RST;
        else if ((gap_cnt == GAP_LAST) && enclk[1])     state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s) state_next = ST_RST;
      end
      default: state_next = ST_RST;
    endcase
  end

  // Next values of counters and outputs; counters not advanced fall to zero.
  always_comb begin
    rst_cnt_next   = '0;
    filt_cnt_next  = '0;
    gap_cnt_next   = '0;
    to_cnt_next    = '0;
    pll_reset_next = pll_reset;
    enclk_next     = enclk;
    ready_next     = ready;
    timeout_next   = 1'b0;
    relock_next    = relock_cnt;
    case (state)
      ST_RST: begin
        pll_reset_next = 1'b1;
        enclk_next     = 3'b000;
        ready_next     = 1'b0;
        if (rst_cnt == RST_LAST) pll_reset_next = 1'b0;
        else                     rst_cnt_next   = rst_cnt + RW'(1);
      end
      ST_WAIT_LOCK: begin
        pll_reset_next = 1'b0;
        if (filt_done) begin
          enclk_next = 3'b001;
        end else begin
          if (lock_s) filt_cnt_next = filt_cnt + FW'(1);
          // Timeout only when the filter has not just completed.
          if (to_cnt == TO_LAST) begin
            timeout_next   = 1'b1;
            pll_reset_next = 1'b1;
          end else begin
            to_cnt_next = to_cnt + TW'(1);
          end
        end
      end
      ST_EN_SEQ, ST_RUN: begin
        if (!lock_s) begin
          enclk_next     = 3'b000;
          ready_next     = 1'b0;
          pll_reset_next = 1'b1;
          if (relock_cnt != 8'hFF) relock_next = relock_cnt + 8'd1;
        end else if (state == ST_EN_SEQ) begin
          if (gap_cnt == GAP_LAST) begin
            if (enclk[1]) begin
              enclk_next = 3'b111;
              ready_next = 1'b1;
            end else begin
              enclk_next = 3'b011;
            end
          end else begin
            gap_cnt_next = gap_cnt + GW'(1);
          end
        end
      end
      default: begin
        pll_reset_next = 1'b1;
        enclk_next     = 3'b000;
        ready_next     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pll_enclk_seq.sv
// Directed bench for pll_enclk_seq: nominal bring-up, lock loss, glitch,
// loss during enable sequencing, timeouts, counter saturation, async reset.
module tb_pll_enclk_seq;

  logic       clkin = 1'b0;
  logic       resetn = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_reset;
  logic [2:0] enclk;
  logic       ready;
  logic [7:0] relock_cnt;
  logic       timeout;

  int  n_run = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  n = 0;
  bit  verbose = 1'b1;
  bit  abort = 1'b0;

  pll_enclk_seq #(
    .RST_CYCLES   (32),
    .LOCK_FILT    (16),
    .EN_GAP       (8),
    .LOCK_TIMEOUT (1024)
  ) dut (
    .clkin      (clkin),
    .resetn     (resetn),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .enclk      (enclk),
    .ready      (ready),
    .relock_cnt (relock_cnt),
    .timeout    (timeout)
  );

  always #5 clkin = ~clkin;

  // One clkin cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clkin);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
    if (verbose && obs === exp)
      $display("[TB] %s cycle %0d value %0h ok", tag, cyc, obs);
  endtask

  initial begin
    // Held in reset: all outputs at reset values.
    repeat (3) @(posedge clkin);
    #1;
    chk("rst_pll_reset", 32'(pll_reset), 32'h1);
    chk("rst_enclk", 32'(enclk), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_relock", 32'(relock_cnt), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);

    // Nominal bring-up: release at cycle 0, lock from cycle 40.
    resetn = 1'b1;
    cyc = 0;
    run_to(31);  chk("nom_prst_31", 32'(pll_reset), 32'h1);
    run_to(32);  chk("nom_prst_32", 32'(pll_reset), 32'h0);
    run_to(40);  pll_lock = 1'b1;
    run_to(57);  chk("nom_en_57", 32'(enclk), 32'h0);
    run_to(58);  chk("nom_en_58", 32'(enclk), 32'h1);
    run_to(65);  chk("nom_en_65", 32'(enclk), 32'h1);
    run_to(66);  chk("nom_en_66", 32'(enclk), 32'h3);
    run_to(73);  chk("nom_en_73", 32'(enclk), 32'h3);
                 chk("nom_rdy_73", 32'(ready), 32'h0);
    run_to(74);  chk("nom_en_74", 32'(enclk), 32'h7);
                 chk("nom_rdy_74", 32'(ready), 32'h1);

    // Lock loss in RUN at RUN+100 (cycle 174): cleared at 177.
    run_to(174); pll_lock = 1'b0;
    run_to(176); chk("loss_en_176", 32'(enclk), 32'h7);
    run_to(177); chk("loss_en_177", 32'(enclk), 32'h0);
                 chk("loss_rdy_177", 32'(ready), 32'h0);
                 chk("loss_relock", 32'(relock_cnt), 32'h1);
                 chk("loss_prst", 32'(pll_reset), 32'h1);
    run_to(208); chk("loss_prst_208", 32'(pll_reset), 32'h1);
    run_to(209); chk("loss_prst_209", 32'(pll_reset), 32'h0);

    // Glitch: high 220..229, low at 230, high from 231 -> enclk[0] at 249.
    run_to(220); pll_lock = 1'b1;
    run_to(230); pll_lock = 1'b0;
    run_to(231); pll_lock = 1'b1;
    run_to(248); chk("glitch_en_248", 32'(enclk), 32'h0);
    run_to(249); chk("glitch_en_249", 32'(enclk), 32'h1);
    run_to(257); chk("glitch_en_257", 32'(enclk), 32'h3);
    run_to(265); chk("glitch_en_265", 32'(enclk), 32'h7);
                 chk("glitch_rdy_265", 32'(ready), 32'h1);

    // Loss coinciding with the enclk[1] step: lock_s low during 365.
    run_to(300); pll_lock = 1'b0;
    run_to(303); chk("seq_relock_2", 32'(relock_cnt), 32'h2);
    run_to(340); pll_lock = 1'b1;
    run_to(358); chk("seq_en_358", 32'(enclk), 32'h1);
    run_to(363); pll_lock = 1'b0;
    run_to(365); chk("seq_en_365", 32'(enclk), 32'h1);
    run_to(366); chk("seq_en_366", 32'(enclk), 32'h0);
                 chk("seq_relock_3", 32'(relock_cnt), 32'h3);
    run_to(370); chk("seq_en_370", 32'(enclk), 32'h0);

    // Timeout: WAIT_LOCK from 398 with no lock -> pulses at 1422, 2478.
    run_to(1421); chk("to_pulse_1421", 32'(timeout), 32'h0);
    run_to(1422); chk("to_pulse_1422", 32'(timeout), 32'h1);
                  chk("to_prst_1422", 32'(pll_reset), 32'h1);
    run_to(1423); chk("to_pulse_1423", 32'(timeout), 32'h0);
                  chk("to_relock", 32'(relock_cnt), 32'h3);
    run_to(2477); chk("to_pulse_2477", 32'(timeout), 32'h0);
    run_to(2478); chk("to_pulse_2478", 32'(timeout), 32'h1);

    // Saturation: 300 more forced losses, each just after enclk[0] rises.
    verbose = 1'b0;
    for (int i = 0; i < 300 && !abort; i++) begin
      pll_lock = 1'b1;
      n = 0;
      while (enclk[0] !== 1'b1 && n < 200) begin step(); n++; end
      chk("sat_en0_wait", 32'(enclk), 32'h1);
      if (enclk !== 3'b001) abort = 1'b1;
      pll_lock = 1'b0;
      n = 0;
      while (enclk !== 3'b000 && n < 10) begin step(); n++; end
      chk("sat_clear_wait", 32'(enclk), 32'h0);
      if (enclk !== 3'b000) abort = 1'b1;
      if (i == 250) begin
        verbose = 1'b1;
        chk("sat_relock_254", 32'(relock_cnt), 32'hFE);
        verbose = 1'b0;
      end
    end
    verbose = 1'b1;
    chk("sat_relock_255", 32'(relock_cnt), 32'hFF);

    // Mid-run asynchronous reset: outputs revert before the next edge.
    pll_lock = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin step(); n++; end
    chk("mid_ready", 32'(ready), 32'h1);
    step(); step(); step();
    resetn = 1'b0;
    #1;
    chk("mid_prst", 32'(pll_reset), 32'h1);
    chk("mid_enclk", 32'(enclk), 32'h0);
    chk("mid_ready0", 32'(ready), 32'h0);
    chk("mid_relock", 32'(relock_cnt), 32'h0);
    chk("mid_timeout", 32'(timeout), 32'h0);
    step(); step();
    chk("mid_hold_en", 32'(enclk), 32'h0);
    chk("mid_hold_prst", 32'(pll_reset), 32'h1);
    resetn = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
